// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Definitions shared by the RISC-V core and its instruction-trace buffer:
//   - trc_state_e    : trace capture FSM encoding (also exported on the debug
//                      `state` port, so the numeric values are fixed)
//   - PSTAGE_DECODED : pipeline-stage code of the post-decode stage, i.e. the
//                      cycle on which pc/idata describe one decoded instruction
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE      = 2'd0,
        TRC_WAIT_TRIG = 2'd1,
        TRC_CAPTURE   = 2'd2,
        TRC_DONE      = 2'd3
    } trc_state_e;

    localparam logic [1:0] PSTAGE_DECODED = 2'b10;

endpackage : core_pkg

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// DEPTH x (2*XLEN+SEQ_W) register array with one synchronous write port and
// one combinational read port. The read data is registered by the owner, so
// the asynchronous read keeps the capture-to-visible latency at one cycle.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data {pc, instr, seq}
//   raddr  in   read address
//   rdata  out  contents at raddr
// -----------------------------------------------------------------------------
module trace_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int W    = 2 * XLEN + SEQ_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Storage write; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : trace_ram

// File: rtl/core_trace_buffer.sv
// -----------------------------------------------------------------------------
// core_trace_buffer
// Captures {pc, idata} on every cycle the core reports the post-decode stage,
// optionally starting at a trigger PC, into a circular buffer with either
// overwrite-oldest (wrap) or stop-when-full policy. Entries are drained in
// order through a valid/ready port with registered outputs.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   pstage     in   core pipeline-stage code
//   pc, idata  in   core program counter / instruction word
//   arm        in   pulse: clear buffer, start a capture session
//   wrap_mode  in   1 = overwrite oldest when full, 0 = stop (sampled at arm)
//   trig_en    in   1 = wait for pc == trig_pc first (sampled at arm)
//   trig_pc    in   trigger address (sampled at arm)
//   rd_valid   out  head entry available
//   rd_ready   in   consumer accepts head entry
//   rd_pc, rd_instr, rd_seq  out  head entry fields
//   count      out  entries held
//   overflow   out  sticky: a capture overwrote an entry or was dropped
//   state      out  FSM state (debug)
// -----------------------------------------------------------------------------
module core_trace_buffer
    import core_pkg::*;
#(
    parameter int                  XLEN          = 32,
    parameter int                  DEPTH         = 16,
    parameter int                  PSTAGE_W      = 2,
    parameter logic [PSTAGE_W-1:0] CAPTURE_STAGE = PSTAGE_W'(PSTAGE_DECODED),
    parameter int                  SEQ_W         = 16,
    localparam int                 PTR_W         = $clog2(DEPTH),
    localparam int                 CNT_W         = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PSTAGE_W-1:0] pstage,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     idata,
    input  logic                arm,
    input  logic                wrap_mode,
    input  logic                trig_en,
    input  logic [XLEN-1:0]     trig_pc,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [XLEN-1:0]     rd_pc,
    output logic [XLEN-1:0]     rd_instr,
    output logic [SEQ_W-1:0]    rd_seq,
    output logic [CNT_W-1:0]    count,
    output logic                overflow,
    output logic [1:0]          state
);

    localparam int ENT_W = 2 * XLEN + SEQ_W;

    trc_state_e        state_r;
    trc_state_e        state_nxt_s;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W-1:0]  head_nxt_s;
    logic [PTR_W-1:0]  tail_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [SEQ_W-1:0]  seq_r;
    logic              overflow_r;
    logic              wrap_r;
    logic [XLEN-1:0]   trig_pc_r;
    logic              rd_valid_r;
    logic [XLEN-1:0]   rd_pc_r;
    logic [XLEN-1:0]   rd_instr_r;
    logic [SEQ_W-1:0]  rd_seq_r;

    logic              event_s;
    logic              trig_hit_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              drop_cond_s;
    logic              want_push_s;
    logic              write_s;
    logic              drop_s;
    logic              overwrite_s;
    logic              rd_load_s;
    logic              bypass_s;
    logic [ENT_W-1:0]  wr_entry_s;
    logic [ENT_W-1:0]  ram_rdata_s;
    logic [ENT_W-1:0]  rd_entry_s;

    assign event_s    = (pstage == CAPTURE_STAGE);
    assign trig_hit_s = (pc == trig_pc_r);
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    // arm wins over a same-cycle pop: the buffer is discarded anyway.
    assign pop_s      = rd_valid_r && rd_ready && !arm;
    // A same-cycle pop frees the slot, so only a full buffer without a pop
    // can force a drop in stop mode.
    assign drop_cond_s = full_s && !pop_s && !wrap_r;
    assign wr_entry_s  = {pc, idata, seq_r};

    // FSM next state and capture request.
    always_comb begin
        state_nxt_s = state_r;
        want_push_s = 1'b0;
        if (arm) begin
            if (trig_en) begin
                state_nxt_s = TRC_WAIT_TRIG;
            end else begin
                state_nxt_s = TRC_CAPTURE;
            end
        end else begin
            case (state_r)
                TRC_IDLE: begin
                    state_nxt_s = TRC_IDLE;
                end
                TRC_WAIT_TRIG: begin
                    if (event_s && trig_hit_s) begin
                        want_push_s = 1'b1;
                        state_nxt_s = drop_cond_s ? TRC_DONE : TRC_CAPTURE;
                    end else begin
                        state_nxt_s = TRC_WAIT_TRIG;
                    end
                end
                TRC_CAPTURE: begin
                    if (event_s) begin
                        want_push_s = 1'b1;
                        state_nxt_s = drop_cond_s ? TRC_DONE : TRC_CAPTURE;
                    end else begin
                        state_nxt_s = TRC_CAPTURE;
                    end
                end
                TRC_DONE: begin
                    state_nxt_s = TRC_DONE;
                end
                default: begin
                    state_nxt_s = TRC_IDLE;
                end
            endcase
        end
    end

    // Pointer / count arithmetic and head-register reload selection.
    always_comb begin
        write_s     = want_push_s && !drop_cond_s;
        drop_s      = want_push_s && drop_cond_s;
        // Full wrap-mode write lands on the head slot, so head moves past it.
        overwrite_s = write_s && full_s && !pop_s;

        if (pop_s || overwrite_s) begin
            head_nxt_s = head_r + PTR_W'(1);
        end else begin
            head_nxt_s = head_r;
        end

        if (write_s) begin
            tail_nxt_s = tail_r + PTR_W'(1);
        end else begin
            tail_nxt_s = tail_r;
        end

        if (write_s && !full_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !write_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end

        // The output register follows the head whenever the head moves or a
        // write lands in an empty buffer. If the new head slot is being
        // written this same edge, the RAM still holds stale data: forward.
        rd_load_s  = pop_s || overwrite_s || (write_s && empty_s);
        bypass_s   = write_s && (tail_r == head_nxt_s);
        if (bypass_s) begin
            rd_entry_s = wr_entry_s;
        end else begin
            rd_entry_s = ram_rdata_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= TRC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Session configuration, latched on arm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_r    <= 1'b0;
            trig_pc_r <= {XLEN{1'b0}};
        end else if (arm) begin
            wrap_r    <= wrap_mode;
            trig_pc_r <= trig_pc;
        end
    end

    // Buffer pointers, occupancy, sequence number and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            seq_r      <= {SEQ_W{1'b0}};
            overflow_r <= 1'b0;
            rd_valid_r <= 1'b0;
        end else if (arm) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            seq_r      <= {SEQ_W{1'b0}};
            overflow_r <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            count_r    <= count_nxt_s;
            rd_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            if (write_s) begin
                seq_r <= seq_r + SEQ_W'(1);
            end
            if (overwrite_s || drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Registered head entry presented on the read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pc_r    <= {XLEN{1'b0}};
            rd_instr_r <= {XLEN{1'b0}};
            rd_seq_r   <= {SEQ_W{1'b0}};
        end else if (arm) begin
            rd_pc_r    <= {XLEN{1'b0}};
            rd_instr_r <= {XLEN{1'b0}};
            rd_seq_r   <= {SEQ_W{1'b0}};
        end else if (rd_load_s) begin
            {rd_pc_r, rd_instr_r, rd_seq_r} <= rd_entry_s;
        end
    end

    trace_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) u_trace_ram (
        .clk   (clk),
        .we    (write_s),
        .waddr (tail_r),
        .wdata (wr_entry_s),
        .raddr (head_nxt_s),
        .rdata (ram_rdata_s)
    );

    assign rd_valid = rd_valid_r;
    assign rd_pc    = rd_pc_r;
    assign rd_instr = rd_instr_r;
    assign rd_seq   = rd_seq_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign state    = state_r;

endmodule : core_trace_buffer

// File: tb/tb_core_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_core_trace_buffer
// Directed scenarios plus a randomized phase. A queue-based model of the trace
// session is advanced on every clock edge from the same inputs the DUT sees;
// a compare process checks the DUT against it on every falling edge. Directed
// scenarios add literal expectations worked out by hand.
// -----------------------------------------------------------------------------
module tb_core_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [1:0]  pstage;
    logic [31:0] pc;
    logic [31:0] idata;
    logic        arm;
    logic        wrap_mode;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [15:0] rd_seq;
    logic [4:0]  count;
    logic        overflow;
    logic [1:0]  state;

    core_trace_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .pstage   (pstage),
        .pc       (pc),
        .idata    (idata),
        .arm      (arm),
        .wrap_mode(wrap_mode),
        .trig_en  (trig_en),
        .trig_pc  (trig_pc),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_instr (rd_instr),
        .rd_seq   (rd_seq),
        .count    (count),
        .overflow (overflow),
        .state    (state)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] seq;
    } ent_t;

    ent_t        mq[$];
    int          m_state;
    int unsigned m_seq;
    bit          m_ovf;
    bit          m_wrap;
    logic [31:0] m_tpc;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_seq   = 0;
        m_ovf   = 1'b0;
        m_wrap  = 1'b0;
        m_tpc   = 32'd0;
    endtask

    // One clock edge of the session rules, applied to the queue.
    task automatic model_apply();
        ent_t e;
        bit   push;
        if (arm) begin
            mq.delete();
            m_seq   = 0;
            m_ovf   = 1'b0;
            m_wrap  = wrap_mode;
            m_tpc   = trig_pc;
            m_state = trig_en ? 1 : 2;
        end else begin
            if (mq.size() != 0 && rd_ready) begin
                void'(mq.pop_front());
            end
            push = (pstage == 2'b10) && (m_state == 2 || (m_state == 1 && pc == m_tpc));
            if (push) begin
                e.pc    = pc;
                e.instr = idata;
                e.seq   = 16'(m_seq);
                if (m_state == 1) m_state = 2;
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                    m_seq++;
                end else if (m_wrap) begin
                    void'(mq.pop_front());
                    mq.push_back(e);
                    m_seq++;
                    m_ovf = 1'b1;
                end else begin
                    m_ovf   = 1'b1;
                    m_state = 3;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT versus model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("state",    64'(state),    64'(m_state));
                chk("count",    64'(count),    64'(mq.size()));
                chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                if (mq.size() != 0) begin
                    chk("rd_pc",    64'(rd_pc),    64'(mq[0].pc));
                    chk("rd_instr", 64'(rd_instr), 64'(mq[0].instr));
                    chk("rd_seq",   64'(rd_seq),   64'(mq[0].seq));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_apply();
        #1;
    endtask

    task automatic do_arm(input logic w, input logic te, input logic [31:0] tp);
        arm       = 1'b1;
        wrap_mode = w;
        trig_en   = te;
        trig_pc   = tp;
        pstage    = 2'b00;
        rd_ready  = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic ev(input logic [31:0] a);
        pstage = 2'b10;
        pc     = a;
        idata  = $urandom;
        tick();
        pstage = 2'b00;
    endtask

    task automatic drain(input int n, input logic [31:0] pc0, input int seq0);
        for (int i = 0; i < n; i++) begin
            chk("drain_pc",  64'(rd_pc),  64'(pc0 + 32'(4 * i)));
            chk("drain_seq", 64'(rd_seq), 64'(seq0 + i));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int bias;
        reset = 1'b1; arm = 1'b0; wrap_mode = 1'b0; trig_en = 1'b0;
        trig_pc = 32'd0; pstage = 2'b00; pc = 32'd0; idata = 32'd0; rd_ready = 1'b0;
        model_reset();

        // Reset asserted mid-cycle, held across edges while pstage toggles.
        #2 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pstage = 2'b10;
            @(negedge clk);
            chk("rst_state",    64'(state),    64'd0);
            chk("rst_count",    64'(count),    64'd0);
            chk("rst_rd_valid", 64'(rd_valid), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
            chk("rst_rd_pc",    64'(rd_pc),    64'd0);
            chk("rst_rd_seq",   64'(rd_seq),   64'd0);
            pstage = 2'b01;
        end
        #10 reset = 1'b1;   // released at 25 ns, between edges
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pstage = (i % 2 == 0) ? 2'b10 : 2'b00;
            pc     = 32'(4 * i);
            tick();
        end
        pstage = 2'b00;
        chk("idle_state", 64'(state), 64'd0);
        chk("idle_count", 64'(count), 64'd0);

        // Free-run capture of five instructions.
        do_arm(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) ev(32'(4 * i));
        chk("free_count", 64'(count), 64'd5);
        chk("free_pc0",   64'(rd_pc), 64'h0);
        chk("free_seq0",  64'(rd_seq), 64'd0);
        drain(5, 32'h0, 0);
        chk("free_empty", 64'(rd_valid), 64'd0);

        // Wrap overflow: 20 events into 16 slots.
        do_arm(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) ev(32'(4 * i));
        chk("wrap_count", 64'(count),    64'd16);
        chk("wrap_ovf",   64'(overflow), 64'd1);
        chk("wrap_seq",   64'(rd_seq),   64'd4);
        chk("wrap_pc",    64'(rd_pc),    64'h10);
        drain(16, 32'h10, 4);

        // Stop mode: the 17th event is dropped and ends the session.
        do_arm(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 18; i++) begin
            ev(32'(4 * i));
            if (i == 15) chk("stop_not_done", 64'(state), 64'd2);
            if (i == 16) chk("stop_done",     64'(state), 64'd3);
        end
        chk("stop_count", 64'(count),    64'd16);
        chk("stop_ovf",   64'(overflow), 64'd1);
        drain(16, 32'h0, 0);
        chk("stop_state_after", 64'(state), 64'd3);

        // Trigger at pc 0x40.
        do_arm(1'b0, 1'b1, 32'h40);
        for (int k = 0; k <= 24; k++) begin
            ev(32'(4 * k));
            if (4 * k < 32'h40) chk("trig_wait", 64'(state), 64'd1);
            else                chk("trig_cap",  64'(state), 64'd2);
        end
        chk("trig_count", 64'(count),  64'd9);
        chk("trig_pc0",   64'(rd_pc),  64'h40);
        chk("trig_seq0",  64'(rd_seq), 64'd0);

        // Full buffer with simultaneous push and pop, then arm mid-readout.
        do_arm(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 16; i++) ev(32'(4 * i));
        chk("pp_full",  64'(count),    64'd16);
        chk("pp_ovf0",  64'(overflow), 64'd0);
        rd_ready = 1'b1;
        ev(32'h100);
        rd_ready = 1'b0;
        chk("pp_count", 64'(count),    64'd16);
        chk("pp_ovf",   64'(overflow), 64'd0);
        chk("pp_seq",   64'(rd_seq),   64'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        arm = 1'b1; trig_en = 1'b0; wrap_mode = 1'b0; pstage = 2'b10; pc = 32'h200;
        tick();
        arm = 1'b0; rd_ready = 1'b0; pstage = 2'b00;
        chk("rearm_count",    64'(count),    64'd0);
        chk("rearm_rd_valid", 64'(rd_valid), 64'd0);

        // Randomized phase.
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: bias = 5;
                    1: bias = 50;
                    default: bias = 95;
                endcase
            end
            arm       = ($urandom_range(0, 63) == 0);
            wrap_mode = 1'($urandom_range(0, 1));
            trig_en   = 1'($urandom_range(0, 1));
            trig_pc   = 32'(4 * $urandom_range(0, 15));
            pstage    = 2'($urandom_range(0, 3));
            pc        = 32'(4 * $urandom_range(0, 15));
            idata     = $urandom;
            rd_ready  = ($urandom_range(0, 99) < bias);
            tick();
        end
        arm = 1'b0; pstage = 2'b00; rd_ready = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_core_trace_buffer

// File: doc/core_trace_buffer.md
# core_trace_buffer

Synthesizable instruction-trace capture buffer for the RISC-V core. It samples `pc`/`idata` on every cycle the core's `pstage` equals the post-decode stage, optionally waiting for a PC trigger. Entries go into a parametrised circular buffer with wrap or stop-when-full policy. A valid/ready port drains the entries in order, so the `$display` trace formerly produced by simulation can come from hardware, a bench or a debug port.

## Interface
Parameters:
- `XLEN`, 32, width of PC and instruction words
- `DEPTH`, 16, entries; power of two, ≥2
- `PSTAGE_W`, 2, width of core pipeline-stage code
- `CAPTURE_STAGE`, 2'b10, `pstage` value that marks a decoded instruction
- `SEQ_W`, 16, width of per-entry sequence number

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `pstage`  in  PSTAGE_W  core stage code
- `pc`  in  XLEN  core program counter
- `idata`  in  XLEN  core instruction word
- `arm`  in  1  pulse: clear buffer and start a capture session
- `wrap_mode`  in  1  1 = overwrite oldest when full, 0 = stop when full; sampled at `arm`
- `trig_en`  in  1  1 = wait for `pc == trig_pc` before capturing; sampled at `arm`
- `trig_pc`  in  XLEN  trigger address; sampled at `arm`
- `rd_valid`  out  1  head entry available
- `rd_ready`  in  1  consumer accepts head entry
- `rd_pc`, `rd_instr`  out  XLEN  head entry fields
- `rd_seq`  out  SEQ_W  head entry sequence number
- `count`  out  clog2(DEPTH)+1  entries held
- `overflow`  out  1  sticky: a capture overwrote or was dropped
- `state`  out  2  FSM state, for debug

## Operation
- FSM states are IDLE(0), WAIT_TRIG(1), CAPTURE(2) and DONE(3).
- IDLE: `arm` clears head, tail, count, overflow and seq. It latches mode, trig_en and trig_pc, then moves to WAIT_TRIG if trig_en, else CAPTURE.
- WAIT_TRIG: a capture event is `pstage == CAPTURE_STAGE`. When a capture event has `pc == trig_pc`, that instruction is captured as seq 0 and the FSM moves to CAPTURE.
- CAPTURE: every capture event writes {pc, idata, seq} at tail, and seq increments, wrapping modulo 2^SEQ_W.
- Full, wrap mode: the new entry overwrites the head entry, head advances, count is unchanged and `overflow` is set.
- Full, stop mode: the entry is dropped, `overflow` is set and the FSM moves to DONE.
- DONE: no captures. The buffer remains readable. `arm` restarts the session.
- `arm` in any state restarts the session, including mid-capture or mid-readout. Pending contents are discarded.
- Readout: `rd_valid = (count != 0)`. A pop happens on `rd_valid && rd_ready`, advancing head and decrementing count. Pops are allowed in every state.
- Simultaneous push and pop:
  - Not full: count unchanged; both pointers advance.
  - Full: the pop frees the slot, so there is no overwrite or drop and `overflow` is not set.
  - Empty with a push: the pop is not taken, because `rd_valid` is 0.
- Pointers are clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: `state` = IDLE; `count` = 0; `rd_valid` = 0; `overflow` = 0; `rd_pc`, `rd_instr` and `rd_seq` = 0; head, tail and seq = 0.
- Capture latency: an event at edge N is visible on `rd_*` after edge N, i.e. in cycle N+1, if the buffer was empty.
- `rd_*` are registered: storage is read at head through an output register updated on push-to-empty or pop. The head entry stays stable while `rd_valid && !rd_ready`.
- `arm` takes priority over a same-cycle capture or pop. At the following edge the buffer is empty.
- The trigger compare is combinational on `pc` and registered into the FSM. The triggering instruction itself is captured.

## Structure
- Shared package `core_pkg` holds the FSM state encoding (`TRC_IDLE`, `TRC_WAIT_TRIG`, `TRC_CAPTURE`, `TRC_DONE`) and the post-decode stage constant (2'b10). `core.v` and this block share it.
- One sub-module: `trace_ram`, a DEPTH×(2·XLEN+SEQ_W) single-write, single-read register array. The FSM and pointers stay in the top level.
- The testbench instantiates the block beside `core` and prints from `rd_*` instead of peeking `core.idata`.

## Test plan
- Reset and defaults:
  - Stimulus: assert reset mid-cycle, release at 25 ns with no `arm`.
  - Required: `state` = 0, `count` = 0, `rd_valid` = 0 throughout, even while `pstage` toggles through 2'b10.
- Free-run capture, DEPTH=16:
  - Stimulus: `arm` with trig_en=0; drive 5 events with pc 0x00,0x04,…,0x10 and `rd_ready` = 0.
  - Required: `count` = 5; `rd_pc` = 0x00 with `rd_seq` = 0; draining yields pcs in order with seq 0..4.
- Wrap overflow:
  - Stimulus: wrap_mode=1; 20 events with pc = 4·i; no reads.
  - Required: `count` = 16, `overflow` = 1, first drained entry has seq 4 and pc 0x10, last has seq 19.
- Stop mode:
  - Stimulus: wrap_mode=0; 18 events.
  - Required: `state` = DONE after event 17; `count` = 16; seq 0..15 drained; `overflow` = 1.
- Trigger:
  - Stimulus: trig_en=1, trig_pc=0x40; events at pc 0x00..0x60 in steps of 4.
  - Required: `state` stays 1 until pc 0x40; first entry is pc 0x40 with seq 0; 9 entries total.
- Full with simultaneous push and pop, then re-arm:
  - Stimulus: fill to 16, then push and pop on the same edge; after that, `arm` mid-readout.
  - Required: `count` stays 16 and `overflow` stays 0 across the push/pop edge; the edge after `arm` gives `count` = 0 and `rd_valid` = 0.
